// File: rtl/cell_array_ctrl.sv
// rtl/cell_array_ctrl.sv - run/capture sequencer for a configurable cell array
// Host registers on S1, config forwarding on S2, run start on S3.
module cell_array_ctrl #(
  parameter int DATA_W = 32,
  parameter int CFG_AW = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [1:0]        s1_address,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic [DATA_W-1:0] s1_readdata,
  input  logic              s2_write,
  input  logic [CFG_AW-1:0] s2_address,
  input  logic [DATA_W-1:0] s2_writedata,
  input  logic              s3_write,
  input  logic [CNT_W-1:0]  s3_writedata,
  output logic              cfg_we,
  output logic [CFG_AW-1:0] cfg_addr,
  output logic [DATA_W-1:0] cfg_data,
  output logic [DATA_W-1:0] arr_in,
  output logic              arr_en,
  input  logic [DATA_W-1:0] arr_out,
  output logic              irq
);

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              run_free;
  logic              mode, irq_en;
  logic              done, aborted, cfg_err, overrun;
  logic [DATA_W-1:0] result;
  logic              busy;
  logic              ctrl_wr, abort_req, irq_clr;
  logic              start, start_zero, start_run, capture;

  always_comb begin
    ctrl_wr    = s1_write && (s1_address == 2'd1);
    abort_req  = ctrl_wr && s1_writedata[1];
    irq_clr    = ctrl_wr && s1_writedata[3];
    start      = s3_write && (state == IDLE);
    // A zero-length single-shot completes straight from IDLE without touching the array
    start_zero = start && !mode && (s3_writedata == '0);
    start_run  = start && !start_zero;
    capture    = (state == CAPTURE);
  end

  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_run) state_nxt = RUN;
      RUN: begin
        if (abort_req)                              state_nxt = CAPTURE;
        else if (!run_free && cnt <= CNT_W'(1))     state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    arr_en = (state == RUN);
    busy   = (state != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt         <= '0;
      run_free    <= 1'b0;
      mode        <= 1'b0;
      irq_en      <= 1'b0;
      arr_in      <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      cfg_err     <= 1'b0;
      overrun     <= 1'b0;
      irq         <= 1'b0;
      result      <= '0;
      cfg_we      <= 1'b0;
      cfg_addr    <= '0;
      cfg_data    <= '0;
      s1_readdata <= '0;
    end else begin
      if (start_run) begin
        cnt      <= s3_writedata;
        run_free <= mode;
      end else if (state == RUN && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (s1_write && s1_address == 2'd0) arr_in <= s1_writedata;
      if (ctrl_wr) begin
        mode   <= s1_writedata[0];
        irq_en <= s1_writedata[2];
      end

      // Sticky flags: a set in the same cycle as irq_clr takes priority
      if (capture || start_zero)        done <= 1'b1;
      else if (start || irq_clr)        done <= 1'b0;

      if (state == RUN && abort_req)    aborted <= 1'b1;
      else if (start || irq_clr)        aborted <= 1'b0;

      if (s2_write && busy)             cfg_err <= 1'b1;
      else if (irq_clr)                 cfg_err <= 1'b0;

      if (s3_write && busy)             overrun <= 1'b1;
      else if (irq_clr)                 overrun <= 1'b0;

      if ((capture || start_zero) && irq_en) irq <= 1'b1;
      else if (irq_clr)                      irq <= 1'b0;

      if (capture) result <= arr_out;

      cfg_we <= s2_write && !busy;
      if (s2_write && !busy) begin
        cfg_addr <= s2_address;
        cfg_data <= s2_writedata;
      end

      if (s1_read) begin
        case (s1_address)
          2'd0:    s1_readdata <= arr_in;
          2'd1:    s1_readdata <= {{(DATA_W-3){1'b0}}, irq_en, 1'b0, mode};
          2'd2:    s1_readdata <= {{(DATA_W-5){1'b0}}, overrun, cfg_err, aborted, done, busy};
          default: s1_readdata <= result;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cell_array_ctrl.sv
// tb/tb_cell_array_ctrl.sv - randomized bench for cell_array_ctrl against a transaction-level model
module tb_cell_array_ctrl;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        s1_read = 1'b0, s1_write = 1'b0;
  logic [1:0]  s1_address = '0;
  logic [31:0] s1_writedata = '0, s1_readdata;
  logic        s2_write = 1'b0;
  logic [8:0]  s2_address = '0;
  logic [31:0] s2_writedata = '0;
  logic        s3_write = 1'b0;
  logic [15:0] s3_writedata = '0;
  logic        cfg_we;
  logic [8:0]  cfg_addr;
  logic [31:0] cfg_data, arr_in;
  logic        arr_en;
  logic [31:0] arr_out = '0;
  logic        irq;

  cell_array_ctrl #(.DATA_W(32), .CFG_AW(9), .CNT_W(16)) dut (
    .clk_in(clk_in), .rst(rst),
    .s1_read(s1_read), .s1_write(s1_write), .s1_address(s1_address),
    .s1_writedata(s1_writedata), .s1_readdata(s1_readdata),
    .s2_write(s2_write), .s2_address(s2_address), .s2_writedata(s2_writedata),
    .s3_write(s3_write), .s3_writedata(s3_writedata),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .arr_in(arr_in), .arr_en(arr_en), .arr_out(arr_out), .irq(irq)
  );

  always #5 clk_in = ~clk_in;

  int passed = 0, total = 0;
  int cyc = 0, k0 = 0;
  int en_cnt = 0, en_rises = 0;
  logic prev_en = 1'b0;
  logic [31:0] hist [1024];
  logic [31:0] rd;

  // Behavioural model of the host-visible state
  logic [31:0] m_in = '0, m_result = '0;
  logic m_mode = 0, m_irq_en = 0, m_done = 0, m_ab = 0, m_cfg = 0, m_ovr = 0, m_irq = 0;

  always @(posedge clk_in) cyc++;

  // arr_out changes every cycle; hist[k] is the word presented after edge k
  always @(posedge clk_in) begin
    #2;
    arr_out = $urandom;
    hist[cyc % 1024] = arr_out;
  end

  always @(negedge clk_in) begin
    if (arr_en) en_cnt++;
    if (arr_en && !prev_en) en_rises++;
    prev_en = arr_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] st(input bit b);
    return {27'd0, m_ovr, m_cfg, m_ab, m_done, b};
  endfunction

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic s1_wr(input logic [1:0] a, input logic [31:0] d);
    s1_write = 1'b1; s1_address = a; s1_writedata = d;
    tick;
    s1_write = 1'b0;
  endtask

  task automatic s1_rd(input logic [1:0] a, output logic [31:0] d);
    s1_read = 1'b1; s1_address = a;
    tick;
    s1_read = 1'b0;
    d = s1_readdata;
  endtask

  task automatic ctrl_write(input bit md, input bit ie, input bit ab, input bit clr);
    s1_wr(2'd1, {28'd0, clr, ie, ab, md});
    m_mode = md; m_irq_en = ie;
    if (clr) begin
      m_done = 0; m_ab = 0; m_cfg = 0; m_ovr = 0; m_irq = 0;
    end
  endtask

  task automatic start_run(input logic [15:0] n);
    s3_write = 1'b1; s3_writedata = n;
    tick;
    s3_write = 1'b0;
    k0 = cyc;
  endtask

  task automatic check_state;
    s1_rd(2'd2, rd); check("status", rd, st(1'b0));
    s1_rd(2'd3, rd); check("result", rd, m_result);
    s1_rd(2'd1, rd); check("ctrl", rd, {29'd0, m_irq_en, 1'b0, m_mode});
    s1_rd(2'd0, rd); check("input_reg", rd, m_in);
    check("irq", 32'(irq), 32'(m_irq));
    check("arr_in", arr_in, m_in);
  endtask

  task automatic run_single(input int n, input bit ie);
    ctrl_write(1'b0, ie, 1'b0, 1'b0);
    en_cnt = 0; en_rises = 0;
    start_run(16'(n));
    s1_rd(2'd2, rd);
    m_ab = 0;
    if (n == 0) begin
      m_done = 1; if (ie) m_irq = 1;
      check("zero_done", rd, st(1'b0));
    end else begin
      m_done = 0;
      check("run_busy", rd, st(1'b1));
      repeat (n) tick;
      m_done = 1; if (ie) m_irq = 1;
      m_result = hist[(k0 + n) % 1024];
    end
    check("en_cycles", 32'(en_cnt), 32'(n));
    check("en_rises", 32'(en_rises), 32'(n > 0));
  endtask

  task automatic busy_run(input int n, input bit ie);
    ctrl_write(1'b0, ie, 1'b0, 1'b0);
    en_cnt = 0;
    start_run(16'(n));
    s3_write = 1'b1; s3_writedata = 16'($urandom);
    s2_write = 1'b1; s2_address = 9'($urandom); s2_writedata = $urandom;
    tick;
    s3_write = 1'b0; s2_write = 1'b0;
    check("cfg_drop", 32'(cfg_we), 32'd0);
    m_ovr = 1; m_cfg = 1; m_done = 0; m_ab = 0;
    s1_rd(2'd2, rd);
    check("busy_status", rd, st(1'b1));
    repeat (n) tick;
    m_done = 1; if (ie) m_irq = 1;
    m_result = hist[(k0 + n) % 1024];
    check("busy_en_cycles", 32'(en_cnt), 32'(n));
  endtask

  task automatic free_abort(input int k, input bit ie, input logic [15:0] n);
    int ab_edge;
    ctrl_write(1'b1, ie, 1'b0, 1'b0);
    en_cnt = 0; en_rises = 0;
    start_run(n);
    m_done = 0; m_ab = 0;
    repeat (k - 1) tick;
    check("free_en_high", 32'(arr_en), 32'd1);
    s1_wr(2'd1, {28'd0, 1'b0, ie, 1'b1, 1'b1});
    ab_edge = cyc;
    check("abort_drop", 32'(arr_en), 32'd0);
    tick;
    check("free_en_cycles", 32'(en_cnt), 32'(k));
    check("free_en_rises", 32'(en_rises), 32'd1);
    m_ab = 1; m_done = 1; if (ie) m_irq = 1;
    m_result = hist[ab_edge % 1024];
    ctrl_write(1'b0, ie, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] d;
    tick; tick;
    check("rst_readdata", s1_readdata, 32'd0);
    check("rst_arr_in", arr_in, 32'd0);
    check("rst_arr_en", 32'(arr_en), 32'd0);
    check("rst_cfg_we", 32'(cfg_we), 32'd0);
    check("rst_cfg_addr", 32'(cfg_addr), 32'd0);
    check("rst_cfg_data", cfg_data, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    check_state;

    // Full config sweep, one word per cycle
    s2_writedata = 32'h5555_5555;
    for (int a = 511; a >= 0; a--) begin
      s2_write = 1'b1; s2_address = 9'(a);
      tick;
      check("sweep_we", 32'(cfg_we), 32'd1);
      check("sweep_addr", 32'(cfg_addr), 32'(a));
      check("sweep_data", cfg_data, 32'h5555_5555);
    end
    s2_write = 1'b0;
    tick;
    check("sweep_we_off", 32'(cfg_we), 32'd0);
    check_state;

    s1_wr(2'd0, 32'hDEAD_BEEF); m_in = 32'hDEAD_BEEF;
    check("arr_in_beef", arr_in, 32'hDEAD_BEEF);
    run_single(100, 1'b0);
    check_state;

    busy_run(5, 1'b1);
    check("irq_after_run", 32'(irq), 32'd1);
    check_state;
    ctrl_write(1'b0, 1'b1, 1'b0, 1'b1);
    check("irq_cleared", 32'(irq), 32'd0);
    check_state;

    free_abort(50, 1'b0, 16'd0);
    check_state;

    // Start and abort together in IDLE: the run proceeds untouched
    ctrl_write(1'b0, 1'b0, 1'b0, 1'b0);
    en_cnt = 0;
    s3_write = 1'b1; s3_writedata = 16'd4;
    s1_write = 1'b1; s1_address = 2'd1; s1_writedata = 32'h2;
    tick;
    s3_write = 1'b0; s1_write = 1'b0;
    k0 = cyc;
    repeat (5) tick;
    check("start_abort_en", 32'(en_cnt), 32'd4);
    m_done = 1; m_ab = 0; m_result = hist[(k0 + 4) % 1024];
    check_state;

    run_single(0, 1'b0);
    check_state;

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          d = $urandom;
          s1_wr(2'd0, d); m_in = d;
          check("rand_arr_in", arr_in, d);
        end
        1: run_single(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
        2: begin
          d = $urandom;
          s2_write = 1'b1; s2_address = 9'(d[8:0] ^ d[31:23]); s2_writedata = d;
          tick;
          s2_write = 1'b0;
          check("rand_cfg_we", 32'(cfg_we), 32'd1);
          check("rand_cfg_addr", 32'(cfg_addr), 32'(d[8:0] ^ d[31:23]));
          check("rand_cfg_data", cfg_data, d);
          tick;
          check("rand_cfg_we_off", 32'(cfg_we), 32'd0);
        end
        3: ctrl_write(1'b0, m_irq_en, 1'b1, 1'($urandom_range(0, 1)));
        4: busy_run(int'($urandom_range(2, 10)), 1'($urandom_range(0, 1)));
        default: free_abort(int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)), 16'($urandom));
      endcase
      check_state;
    end

    // Reset in the middle of a long run
    s1_wr(2'd0, 32'hA5A5_5A5A); m_in = 32'hA5A5_5A5A;
    ctrl_write(1'b0, 1'b1, 1'b0, 1'b0);
    start_run(16'd1000);
    repeat (20) tick;
    check("long_run_en", 32'(arr_en), 32'd1);
    s1_rd(2'd0, rd);
    rst = 1'b1;
    tick;
    check("mid_rst_arr_en", 32'(arr_en), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_readdata", s1_readdata, 32'd0);
    check("mid_rst_arr_in", arr_in, 32'd0);
    check("mid_rst_cfg_we", 32'(cfg_we), 32'd0);
    check("mid_rst_cfg_addr", 32'(cfg_addr), 32'd0);
    check("mid_rst_cfg_data", cfg_data, 32'd0);
    rst = 1'b0;
    m_in = '0; m_result = '0; m_mode = 0; m_irq_en = 0;
    m_done = 0; m_ab = 0; m_cfg = 0; m_ovr = 0; m_irq = 0;
    repeat (3) tick;
    check("post_rst_arr_en", 32'(arr_en), 32'd0);
    check_state;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
